// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//
// Reset/run sequencer. After rst_n is released it holds every downstream
// channel reset asserted for HOLD_CYCLES, then releases the NUM_CH channel
// resets one at a time, STAGE_GAP cycles apart, in bit order. Once the last
// channel is out of reset it counts a RUN_CYCLES window and raises a sticky
// done flag. A soft_rst_req pulse restarts the whole sequence from HOLD.
//
// Ports
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       synchronous active-low reset (highest priority)
//   soft_rst_req  in   1       synchronous restart request, same effect as reset
//   ch_rst_n      out  NUM_CH  per-channel active-low reset, bit k released k-th
//   all_released  out  1       high once every ch_rst_n bit is 1
//   run_cnt       out  CNT_W   cycles elapsed in the run window
//   done          out  1       sticky: run window complete
//   state         out  2       debug: 0=HOLD 1=RELEASE 2=RUN 3=DONE
//
// All outputs come straight from flops. Counters compare against their
// terminal value before incrementing, so they never wrap.
// -----------------------------------------------------------------------------
module rst_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 100,
    parameter int STAGE_GAP   = 8,
    parameter int RUN_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              all_released,
    output logic [CNT_W-1:0]  run_cnt,
    output logic              done,
    output logic [1:0]        state
);

    // ch_idx must be able to hold NUM_CH (it steps past the last channel).
    localparam int IDX_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [IDX_W-1:0]   ch_idx_r;
    logic [IDX_W-1:0]   ch_idx_nx_s;
    logic [NUM_CH-1:0]  ch_rst_n_r;
    logic [NUM_CH-1:0]  ch_rst_n_nx_s;
    logic               all_released_r;
    logic               all_released_nx_s;
    logic [CNT_W-1:0]   run_cnt_r;
    logic [CNT_W-1:0]   run_cnt_nx_s;
    logic [CNT_W-1:0]   run_inc_s;
    logic               done_r;
    logic               done_nx_s;
    logic               restart_s;

    // Hard reset and soft restart collapse to the same restart condition.
    always_comb begin
        restart_s = (~rst_n) | soft_rst_req;
        run_inc_s = run_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nx_s        = state_r;
        cnt_nx_s          = cnt_r;
        ch_idx_nx_s       = ch_idx_r;
        ch_rst_n_nx_s     = ch_rst_n_r;
        all_released_nx_s = all_released_r;
        run_cnt_nx_s      = run_cnt_r;
        done_nx_s         = done_r;

        case (state_r)
            ST_HOLD: begin
                if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
                    ch_rst_n_nx_s[0] = 1'b1;
                    cnt_nx_s         = {CNT_W{1'b0}};
                    ch_idx_nx_s      = IDX_W'(1);
                    if (NUM_CH == 1) begin
                        // Single channel: the first release is also the last.
                        all_released_nx_s = 1'b1;
                        state_nx_s        = ST_RUN;
                    end else begin
                        state_nx_s = ST_RELEASE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_RELEASE: begin
                if (cnt_r == CNT_W'(STAGE_GAP - 1)) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_idx_r == IDX_W'(k)) begin
                            ch_rst_n_nx_s[k] = 1'b1;
                        end else begin
                            ch_rst_n_nx_s[k] = ch_rst_n_r[k];
                        end
                    end
                    cnt_nx_s    = {CNT_W{1'b0}};
                    ch_idx_nx_s = ch_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (ch_idx_r == IDX_W'(NUM_CH - 1)) begin
                        // all_released rises on the same edge as the last bit.
                        all_released_nx_s = 1'b1;
                        state_nx_s        = ST_RUN;
                    end else begin
                        state_nx_s = ST_RELEASE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_RUN: begin
                run_cnt_nx_s = run_inc_s;
                if (run_inc_s == CNT_W'(RUN_CYCLES)) begin
                    done_nx_s  = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end

            ST_DONE: begin
                state_nx_s = ST_DONE;
            end

            default: begin
                state_nx_s = ST_HOLD;
            end
        endcase
    end

    // Sequencer registers; restart returns everything to the HOLD start point.
    always_ff @(posedge clk) begin
        if (restart_s) begin
            state_r        <= ST_HOLD;
            cnt_r          <= {CNT_W{1'b0}};
            ch_idx_r       <= {IDX_W{1'b0}};
            ch_rst_n_r     <= {NUM_CH{1'b0}};
            all_released_r <= 1'b0;
            run_cnt_r      <= {CNT_W{1'b0}};
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            cnt_r          <= cnt_nx_s;
            ch_idx_r       <= ch_idx_nx_s;
            ch_rst_n_r     <= ch_rst_n_nx_s;
            all_released_r <= all_released_nx_s;
            run_cnt_r      <= run_cnt_nx_s;
            done_r         <= done_nx_s;
        end
    end

    // Outputs are taken directly from the registers.
    always_comb begin
        ch_rst_n     = ch_rst_n_r;
        all_released = all_released_r;
        run_cnt      = run_cnt_r;
        done         = done_r;
        state        = state_r;
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
//
// Drives two sequencers from shared rst_n/soft_rst_req: one with default
// parameters, one with NUM_CH=1, HOLD=3, GAP=5, RUN=1. Every edge the stimulus
// pushes the expected outputs (from the documented release/done timing) into a
// queue per instance; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

    typedef struct {
        int ch;
        int all;
        int run;
        int dn;
        int st;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        soft_rst_req;
    logic [3:0]  ch_a;
    logic        all_a;
    logic [15:0] run_a;
    logic        done_a;
    logic [1:0]  st_a;
    logic [0:0]  ch_b;
    logic        all_b;
    logic [7:0]  run_b;
    logic        done_b;
    logic [1:0]  st_b;

    int   total = 0;
    int   bad   = 0;
    int   na    = -1;
    int   nb    = -1;
    exp_t qa[$];
    exp_t qb[$];

    rst_seq_gen u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .ch_rst_n     (ch_a),
        .all_released (all_a),
        .run_cnt      (run_a),
        .done         (done_a),
        .state        (st_a)
    );

    rst_seq_gen #(
        .NUM_CH      (1),
        .HOLD_CYCLES (3),
        .STAGE_GAP   (5),
        .RUN_CYCLES  (1),
        .CNT_W       (8)
    ) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .ch_rst_n     (ch_b),
        .all_released (all_b),
        .run_cnt      (run_b),
        .done         (done_b),
        .state        (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after edge En (n<0 means the edge applied a reset).
    function automatic exp_t expect_at(int n, int h, int g, int nch, int r);
        exp_t e;
        int   last;
        last  = h - 1 + (nch - 1) * g;
        e.ch  = 0;
        e.all = 0;
        e.run = 0;
        e.dn  = 0;
        e.st  = 0;
        if (n >= 0) begin
            for (int k = 0; k < nch; k++)
                if (n >= h - 1 + k * g) e.ch = e.ch | (1 << k);
            e.all = (n >= last) ? 1 : 0;
            e.run = (n <= last) ? 0 : ((n - last > r) ? r : n - last);
            e.dn  = (n >= last + r) ? 1 : 0;
            if (n < h - 1)         e.st = 0;
            else if (n < last)     e.st = 1;
            else if (n < last + r) e.st = 2;
            else                   e.st = 3;
        end
        return e;
    endfunction

    // Apply inputs for one edge, then record what that edge must produce.
    task automatic tick(input logic r, input logic s);
        rst_n        = r;
        soft_rst_req = s;
        @(posedge clk);
        if (!r || s) begin
            na = -1;
            nb = -1;
        end else begin
            na = na + 1;
            nb = nb + 1;
        end
        qa.push_back(expect_at(na, 100, 8, 4, 10));
        qb.push_back(expect_at(nb, 3, 5, 1, 1));
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        total = total + 1;
        if (act != exp_v) begin
            bad = bad + 1;
            $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, exp_v);
        end
    endtask

    // Monitor: compare each DUT against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_ch_rst_n", int'(ch_a), e.ch);
            chk("a_all_released", int'(all_a), e.all);
            chk("a_run_cnt", int'(run_a), e.run);
            chk("a_done", int'(done_a), e.dn);
            chk("a_state", int'(st_a), e.st);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_ch_rst_n", int'(ch_b), e.ch);
            chk("b_all_released", int'(all_b), e.all);
            chk("b_run_cnt", int'(run_b), e.run);
            chk("b_done", int'(done_b), e.dn);
            chk("b_state", int'(st_b), e.st);
        end
    end

    initial begin
        rst_n        = 1'b0;
        soft_rst_req = 1'b0;

        // Power-on: rst_n low 10 edges, then the full sequence to DONE.
        repeat (10) tick(1'b0, 1'b0);
        repeat (140) tick(1'b1, 1'b0);

        // Soft restart pulse at E110 with ch0/ch1 already released.
        repeat (2) tick(1'b0, 1'b0);
        while (na < 109) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (130) tick(1'b1, 1'b0);

        // rst_n low at E128 (mid-RUN), then the sequence repeats.
        tick(1'b0, 1'b0);
        while (na < 127) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        repeat (140) tick(1'b1, 1'b0);

        // rst_n and soft_rst_req together, then a full sequence.
        repeat (2) tick(1'b0, 1'b1);
        repeat (140) tick(1'b1, 1'b0);

        // soft_rst_req held 20 edges after done, then a short restart.
        repeat (20) tick(1'b1, 1'b1);
        repeat (5) tick(1'b1, 1'b0);

        // Let the monitor drain the last expectations, bounded.
        repeat (3) @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain pending_a=%0d pending_b=%0d", qa.size(), qb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t act=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
